// File: rtl/dmem_responder.sv
// dmem_responder: LEGv8 data memory with a hardware dump sequencer.
// A rising edge of dump streams every word, one per cycle, on dump_*.
// Ports: clk, reset (async, active-high); core side memWrite, memRead,
// address, writeData, readData; debug side dump (level request),
// dump_valid/dump_addr/dump_data (registered word stream),
// dump_busy (walking memory), dump_done (walk finished, waiting for dump=0).
// Optional: DMEM_DUMP_SKIP_ZERO_EN suppresses dump_valid for zero words.
module dmem_responder #(
  parameter int N      = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memWrite,
  input  logic              memRead,
  input  logic [ADDR_W-1:0] address,
  input  logic [N-1:0]      writeData,
  output logic [N-1:0]      readData,
  input  logic              dump,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [N-1:0]      dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DUMP,
    S_DONE
  } state_t;

  logic [N-1:0]      r_mem [DEPTH];
  logic              r_dump_q;
  state_t            r_state;
  logic [ADDR_W:0]   r_cnt;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [N-1:0]      r_data;

  logic              w_start;
  logic [ADDR_W-1:0] w_idx;
  logic [N-1:0]      w_word;
  logic              w_emit;

  assign w_start = dump & ~r_dump_q;
  assign w_idx   = r_cnt[ADDR_W-1:0];
  assign w_word  = r_mem[w_idx];

`ifdef DMEM_DUMP_SKIP_ZERO_EN
  assign w_emit = (w_word != '0);
`else
  assign w_emit = 1'b1;
`endif

  assign readData = memRead ? r_mem[address] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (memWrite) begin
      r_mem[address] <= writeData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dump_q <= 1'b0;
    end else begin
      r_dump_q <= dump;
    end
  end

  // The extra cnt bit marks "all words emitted": the move to DONE happens
  // one edge after the last word so that word keeps a full valid cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (w_start) begin
            r_state <= S_DUMP;
            r_cnt   <= '0;
          end
        end
        S_DUMP: begin
          if (r_cnt[ADDR_W]) begin
            r_valid <= 1'b0;
            r_state <= S_DONE;
          end else begin
            // r_mem read here is the pre-write value on a colliding edge
            r_valid <= w_emit;
            r_addr  <= w_idx;
            r_data  <= w_word;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          if (!dump) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dump_valid = r_valid;
  assign dump_addr  = r_addr;
  assign dump_data  = r_data;
  assign dump_busy  = (r_state == S_DUMP);
  assign dump_done  = (r_state == S_DONE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed stimulus for dmem_responder,
// checked against a word-array model with an edges-since-start counter.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memWrite = 1'b0;
  logic        memRead = 1'b0;
  logic [5:0]  address = '0;
  logic [63:0] writeData = '0;
  logic [63:0] readData;
  logic        dump = 1'b0;
  logic        dump_valid;
  logic [5:0]  dump_addr;
  logic [63:0] dump_data;
  logic        dump_busy;
  logic        dump_done;

  dmem_responder #(.N(64), .ADDR_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .memWrite(memWrite),
    .memRead(memRead),
    .address(address),
    .writeData(writeData),
    .readData(readData),
    .dump(dump),
    .dump_valid(dump_valid),
    .dump_addr(dump_addr),
    .dump_data(dump_data),
    .dump_busy(dump_busy),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_seen = 0;

  // model: memory contents plus edges elapsed since the dump start
  // (-1 = no dump, 0..64 = walking, 65 = finished)
  logic [63:0] m_mem [64];
  int          m_t = -1;
  bit          m_dq = 0;
  logic        e_valid = 0;
  logic [5:0]  e_addr = 0;
  logic [63:0] e_data = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    m_t = -1;
    m_dq = 0;
    e_valid = 0;
    e_addr = 0;
    e_data = 0;
  endtask

  task automatic chk_dump();
    check("dvalid", 64'(dump_valid), 64'(e_valid));
    check("daddr", 64'(dump_addr), 64'(e_addr));
    check("ddata", dump_data, e_data);
    check("busy", 64'(dump_busy), 64'(m_t >= 0 && m_t <= 64));
    check("done", 64'(dump_done), 64'(m_t == 65));
  endtask

  task automatic cycle(input logic we, input logic re,
                       input logic [5:0] a, input logic [63:0] wd,
                       input logic dmp);
    @(negedge clk);
    memWrite = we;
    memRead = re;
    address = a;
    writeData = wd;
    dump = dmp;
    #1;
    check("rdata", readData, re ? m_mem[a] : 64'd0);
    if (m_t < 0) begin
      if (dmp && !m_dq) m_t = 0;
    end else if (m_t < 65) begin
      m_t++;
      if (m_t <= 64) begin
        e_addr = 6'(m_t - 1);
        e_data = m_mem[m_t-1];
`ifdef DMEM_DUMP_SKIP_ZERO_EN
        e_valid = (e_data != 0);
`else
        e_valid = 1'b1;
`endif
      end else begin
        e_valid = 1'b0;
      end
    end else if (!dmp) begin
      m_t = -1;
    end
    if (we) m_mem[a] = wd;
    m_dq = dmp;
    @(posedge clk);
    #1;
    if (dump_valid) n_seen++;
    chk_dump();
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    memRead = 1'b0;
    memWrite = 1'b0;
    dump = 1'b0;
    #1;
    model_clear();
    chk_dump();
    check("rst_rd", readData, 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic d;
    int seen_exp;
    model_clear();
    #1;
    chk_dump();
    check("rst_rd0", readData, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // reset cleared memory
    cycle(0, 1, 6'd0, 0, 0);
    cycle(0, 1, 6'd31, 0, 0);
    cycle(0, 1, 6'd63, 0, 0);

    // write then read
    cycle(1, 0, 6'd5, 64'h00000000DEADBEEF, 0);
    cycle(0, 1, 6'd5, 0, 0);
    check("wr_rd", readData, 64'h00000000DEADBEEF);
    cycle(0, 0, 6'd5, 0, 0);

    // full dump of mem[i] = i+1, dump held past the end
    for (int i = 0; i < 64; i++) cycle(1, 0, 6'(i), 64'(i + 1), 0);
    n_seen = 0;
    for (int j = 0; j < 72; j++) cycle(0, 0, 0, 0, 1);
    check("full_cnt", 64'(n_seen), 64'd64);
    check("done_held", 64'(dump_done), 64'd1);
    cycle(0, 0, 0, 0, 0);
    check("back_idle", 64'(dump_busy | dump_done), 64'd0);
    cycle(0, 0, 0, 0, 0);

    // second dump with a collision on word 10
    cycle(1, 0, 6'd10, 64'hAA, 0);
    n_seen = 0;
    for (int j = 0; j < 67; j++) begin
      if (j == 11) cycle(1, 0, 6'd10, 64'hBB, 1);
      else cycle(0, 0, 0, 0, 1);
      if (j == 11) check("coll_old", dump_data, 64'hAA);
    end
    check("dump2_cnt", 64'(n_seen), 64'd64);
    cycle(0, 1, 6'd10, 0, 0);
    check("coll_new", readData, 64'hBB);

    // reset after 20 dumped words
    for (int j = 0; j < 21; j++) cycle(0, 0, 0, 0, 1);
    check("pre_rst_addr", 64'(dump_addr), 64'd19);
    mid_reset();
    for (int j = 0; j < 5; j++) cycle(0, 1, 6'(j), 0, 0);

    // sparse memory: only words 3 and 40 nonzero
    cycle(1, 0, 6'd3, 64'h33, 0);
    cycle(1, 0, 6'd40, 64'h4040, 0);
    n_seen = 0;
    for (int j = 0; j < 68; j++) cycle(0, 0, 0, 0, 1);
`ifdef DMEM_DUMP_SKIP_ZERO_EN
    seen_exp = 2;
`else
    seen_exp = 64;
`endif
    check("sparse_cnt", 64'(n_seen), 64'(seen_exp));
    cycle(0, 0, 0, 0, 0);

    // random traffic with occasional dump toggles
    d = 0;
    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(0, 29) == 0) d = ~d;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            6'($urandom_range(0, 63)),
            {$urandom, $urandom} & ($urandom_range(0, 2) == 0 ? 64'd0 : '1),
            d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
